// File: rtl/cnn_pkg.sv
// Shared types and widths for the CNN training core and its sequencer.
package cnn_pkg;

    localparam int unsigned Q_WIDTH    = 16;
    localparam int unsigned Q_FRAC     = 8;
    localparam int unsigned LOSS_WIDTH = 32;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LAUNCH,
        WAIT,
        COMMIT,
        EPOCH_END,
        DONE,
        ERROR
    } seq_state_t;

endpackage

// File: rtl/abs_err_accum.sv
// Accumulates |pred - label| over Q8.8 samples into a saturating unsigned sum.
module abs_err_accum
    import cnn_pkg::*;
#(
    parameter int unsigned SUM_WIDTH = LOSS_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    input  logic                 en,
    input  logic [Q_WIDTH-1:0]   pred,
    input  logic [Q_WIDTH-1:0]   label,
    output logic [SUM_WIDTH-1:0] sum
);

    localparam int unsigned DIFF_WIDTH = Q_WIDTH + 1;

    logic [DIFF_WIDTH-1:0] diff;
    logic [Q_WIDTH-1:0]    abs_diff;
    logic [SUM_WIDTH:0]    sum_ext;

    // 17-bit signed difference cannot overflow; its magnitude fits in 16 bits
    always_comb begin
        diff     = {pred[Q_WIDTH-1], pred} - {label[Q_WIDTH-1], label};
        abs_diff = diff[DIFF_WIDTH-1] ? Q_WIDTH'(-diff) : Q_WIDTH'(diff);
        sum_ext  = {1'b0, sum} + (SUM_WIDTH + 1)'(abs_diff);
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            sum <= '0;
        end else if (en) begin
            sum <= sum_ext[SUM_WIDTH] ? '1 : sum_ext[SUM_WIDTH-1:0];
        end
    end

endmodule

// File: rtl/cnn_train_sequencer.sv
// Training-loop sequencer: fetch sample, launch core, await done under timeout,
// commit weights, and track sample/epoch indices and per-epoch absolute error.
module cnn_train_sequencer
    import cnn_pkg::*;
#(
    parameter int unsigned NUM_SAMPLES = 16,
    parameter int unsigned NUM_EPOCHS  = 4,
    parameter int unsigned TIMEOUT     = 16
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               cmd_start,
    input  logic                               cmd_abort,
    input  logic                               sample_valid,
    output logic                               sample_ready,
    input  logic [Q_WIDTH-1:0]                 label,
    output logic                               core_start,
    input  logic                               core_done,
    input  logic [Q_WIDTH-1:0]                 core_output,
    output logic                               weight_commit,
    output logic [$clog2(NUM_SAMPLES+1)-1:0]   sample_idx,
    output logic [$clog2(NUM_EPOCHS+1)-1:0]    epoch_idx,
    output logic                               busy,
    output logic                               epoch_done,
    output logic [LOSS_WIDTH-1:0]              epoch_loss,
    output logic                               train_done,
    output logic                               error
);

    localparam int unsigned SIDX_W = $clog2(NUM_SAMPLES + 1);
    localparam int unsigned EIDX_W = $clog2(NUM_EPOCHS + 1);
    localparam int unsigned WCNT_W = $clog2(TIMEOUT);

    seq_state_t            state;
    seq_state_t            state_next;
    logic [WCNT_W-1:0]     wait_cnt;
    logic [LOSS_WIDTH-1:0] acc_sum;
    logic                  last_sample;
    logic                  last_epoch;
    logic                  timeout_hit;
    logic                  start_run_c;
    logic                  acc_en_c;
    logic                  acc_clear_c;

    assign last_sample = (sample_idx == SIDX_W'(NUM_SAMPLES - 1));
    assign last_epoch  = (epoch_idx == EIDX_W'(NUM_EPOCHS - 1));
    assign timeout_hit = (wait_cnt == WCNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and accumulator control; abort overrides everything
    always_comb begin
        state_next  = state;
        start_run_c = 1'b0;
        acc_en_c    = 1'b0;
        acc_clear_c = 1'b0;
        case (state)
            IDLE:      if (cmd_start) state_next = FETCH;
            FETCH:     if (sample_valid) state_next = LAUNCH;
            LAUNCH:    state_next = WAIT;
            WAIT: begin
                if (core_done) begin
                    state_next = COMMIT;
                end else if (timeout_hit) begin
                    state_next = ERROR;
                end
            end
            COMMIT:    state_next = last_sample ? EPOCH_END : FETCH;
            EPOCH_END: state_next = last_epoch ? DONE : FETCH;
            DONE:      state_next = IDLE;
            ERROR:     if (cmd_start) state_next = FETCH;
            default:   state_next = IDLE;
        endcase
        if (cmd_abort) begin
            state_next = IDLE;
        end else begin
            start_run_c = cmd_start && (state == IDLE || state == ERROR);
            acc_en_c    = (state == WAIT) && core_done;
        end
        acc_clear_c = cmd_abort || start_run_c || (state == EPOCH_END);
    end

    // Pulses are registered decodes of the upcoming state
    always_ff @(posedge clk) begin
        if (rst) begin
            sample_ready  <= 1'b0;
            core_start    <= 1'b0;
            weight_commit <= 1'b0;
            epoch_done    <= 1'b0;
            train_done    <= 1'b0;
            busy          <= 1'b0;
            error         <= 1'b0;
            wait_cnt      <= '0;
            sample_idx    <= '0;
            epoch_idx     <= '0;
            epoch_loss    <= '0;
        end else begin
            sample_ready  <= (state_next == FETCH);
            core_start    <= (state_next == LAUNCH);
            weight_commit <= (state_next == COMMIT);
            epoch_done    <= (state_next == EPOCH_END);
            train_done    <= (state_next == DONE);
            busy          <= !(state_next inside {IDLE, DONE, ERROR});
            wait_cnt      <= (state == WAIT) ? wait_cnt + WCNT_W'(1) : '0;

            if (cmd_abort || start_run_c) begin
                sample_idx <= '0;
            end else if (state == COMMIT) begin
                sample_idx <= last_sample ? '0 : sample_idx + SIDX_W'(1);
            end

            if (cmd_abort || start_run_c || state_next == IDLE) begin
                epoch_idx <= '0;
            end else if (state == EPOCH_END) begin
                epoch_idx <= epoch_idx + EIDX_W'(1);
            end

            if (cmd_abort || start_run_c) begin
                error <= 1'b0;
            end else if (state_next == ERROR) begin
                error <= 1'b1;
            end

            if (state == EPOCH_END && !cmd_abort) begin
                epoch_loss <= acc_sum;
            end
        end
    end

    abs_err_accum #(
        .SUM_WIDTH (LOSS_WIDTH)
    ) u_accum (
        .clk   (clk),
        .rst   (rst),
        .clear (acc_clear_c),
        .en    (acc_en_c),
        .pred  (core_output),
        .label (label),
        .sum   (acc_sum)
    );

endmodule

// File: tb/tb_cnn_train_sequencer.sv
// Randomized self-checking bench for cnn_train_sequencer and its error accumulator.
module tb_cnn_train_sequencer;

    localparam int unsigned NS  = 3;
    localparam int unsigned NE  = 2;
    localparam int unsigned TO  = 16;
    localparam int unsigned AW  = 20;
    localparam longint      AMAX = (longint'(1) << AW) - 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_start = 1'b0;
    logic        cmd_abort = 1'b0;
    logic        sample_valid = 1'b0;
    logic        core_done = 1'b0;
    logic [15:0] label = '0;
    logic [15:0] core_output = '0;
    logic        sample_ready, core_start, weight_commit, busy;
    logic        epoch_done, train_done, error;
    logic [1:0]  sample_idx;
    logic [1:0]  epoch_idx;
    logic [31:0] epoch_loss;

    logic          a_clear = 1'b0;
    logic          a_en = 1'b0;
    logic [15:0]   a_pred = '0;
    logic [15:0]   a_label = '0;
    logic [AW-1:0] a_sum;

    int     vectors = 0;
    int     miscompares = 0;
    int     n_commit = 0;
    int     n_edone = 0;
    int     n_tdone = 0;
    longint exp_loss = 0;
    logic [31:0] last_loss = '0;

    always #5 clk = ~clk;

    cnn_train_sequencer #(
        .NUM_SAMPLES (NS),
        .NUM_EPOCHS  (NE),
        .TIMEOUT     (TO)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .cmd_start     (cmd_start),
        .cmd_abort     (cmd_abort),
        .sample_valid  (sample_valid),
        .sample_ready  (sample_ready),
        .label         (label),
        .core_start    (core_start),
        .core_done     (core_done),
        .core_output   (core_output),
        .weight_commit (weight_commit),
        .sample_idx    (sample_idx),
        .epoch_idx     (epoch_idx),
        .busy          (busy),
        .epoch_done    (epoch_done),
        .epoch_loss    (epoch_loss),
        .train_done    (train_done),
        .error         (error)
    );

    abs_err_accum #(
        .SUM_WIDTH (AW)
    ) acc (
        .clk   (clk),
        .rst   (rst),
        .clear (a_clear),
        .en    (a_en),
        .pred  (a_pred),
        .label (a_label),
        .sum   (a_sum)
    );

    always @(negedge clk) begin
        if (weight_commit) n_commit++;
        if (epoch_done)    n_edone++;
        if (train_done)    n_tdone++;
    end

    function automatic longint abs_err(input logic [15:0] o, input logic [15:0] l);
        longint d;
        d = longint'($signed(o)) - longint'($signed(l));
        return (d < 0) ? -d : d;
    endfunction

    task automatic step();
        @(negedge clk);
    endtask

    // One sample from FETCH through COMMIT; returns positioned in the COMMIT cycle
    task automatic do_sample(input int e, input int s, input int gap, input int lat, input bit spur);
        logic [15:0] o;
        logic [15:0] l;
        o = 16'($urandom);
        l = 16'($urandom);
        sample_valid = 1'b0;
        for (int i = 0; i < gap; i++) begin
            vectors++;
            if ({sample_ready, core_start, busy} !== 3'b101) begin
                miscompares++;
                $display("FAIL fetch_hold e%0d s%0d: ready/start/busy=%b want 101", e, s, {sample_ready, core_start, busy});
            end
            step();
        end
        vectors++;
        if ({sample_ready, core_start, sample_idx, epoch_idx} !== {1'b1, 1'b0, 2'(s), 2'(e)}) begin
            miscompares++;
            $display("FAIL fetch e%0d s%0d: ready/start/sidx/eidx=%b want %b", e, s,
                     {sample_ready, core_start, sample_idx, epoch_idx}, {1'b1, 1'b0, 2'(s), 2'(e)});
        end
        sample_valid = 1'b1;
        label = l;
        step();
        sample_valid = 1'b0;
        core_done = spur;
        core_output = spur ? 16'($urandom) : 16'h0;
        vectors++;
        if ({core_start, sample_ready, weight_commit, busy} !== 4'b1001) begin
            miscompares++;
            $display("FAIL launch e%0d s%0d: start/ready/commit/busy=%b want 1001", e, s,
                     {core_start, sample_ready, weight_commit, busy});
        end
        step();
        core_done = 1'b0;
        for (int i = 0; i < lat; i++) begin
            cmd_start = 1'($urandom);
            vectors++;
            if ({core_start, weight_commit, busy, error} !== 4'b0010) begin
                miscompares++;
                $display("FAIL wait e%0d s%0d cyc%0d: start/commit/busy/err=%b want 0010", e, s, i,
                         {core_start, weight_commit, busy, error});
            end
            step();
        end
        cmd_start = 1'b0;
        core_done = 1'b1;
        core_output = o;
        step();
        core_done = 1'b0;
        exp_loss += abs_err(o, l);
        vectors++;
        if ({weight_commit, core_start, sample_ready, sample_idx} !== {3'b100, 2'(s)}) begin
            miscompares++;
            $display("FAIL commit e%0d s%0d: commit/start/ready/sidx=%b want %b", e, s,
                     {weight_commit, core_start, sample_ready, sample_idx}, {3'b100, 2'(s)});
        end
    endtask

    // From the last COMMIT of epoch e through EPOCH_END to FETCH, or DONE then IDLE
    task automatic do_epoch_end(input int e);
        step();
        vectors++;
        if ({epoch_done, weight_commit, busy, sample_idx, epoch_idx} !== {3'b101, 2'd0, 2'(e)}) begin
            miscompares++;
            $display("FAIL epoch_end e%0d: edone/commit/busy/sidx/eidx=%b want %b", e,
                     {epoch_done, weight_commit, busy, sample_idx, epoch_idx}, {3'b101, 2'd0, 2'(e)});
        end
        step();
        last_loss = 32'(exp_loss);
        exp_loss = 0;
        vectors++;
        if (epoch_loss !== last_loss) begin
            miscompares++;
            $display("FAIL epoch_loss e%0d: got %h want %h", e, epoch_loss, last_loss);
        end
        if (e < int'(NE) - 1) begin
            vectors++;
            if ({sample_ready, epoch_done, epoch_idx} !== {2'b10, 2'(e + 1)}) begin
                miscompares++;
                $display("FAIL next_epoch e%0d: ready/edone/eidx=%b want %b", e,
                         {sample_ready, epoch_done, epoch_idx}, {2'b10, 2'(e + 1)});
            end
        end else begin
            vectors++;
            if ({train_done, busy, epoch_done, epoch_idx} !== {3'b100, 2'(NE)}) begin
                miscompares++;
                $display("FAIL done: tdone/busy/edone/eidx=%b want %b",
                         {train_done, busy, epoch_done, epoch_idx}, {3'b100, 2'(NE)});
            end
            step();
            vectors++;
            if ({train_done, busy, sample_ready, epoch_idx, sample_idx} !== 7'b0) begin
                miscompares++;
                $display("FAIL idle_after_done: tdone/busy/ready/eidx/sidx=%b want 0",
                         {train_done, busy, sample_ready, epoch_idx, sample_idx});
            end
        end
    endtask

    // Runs every epoch starting from the first FETCH cycle with the model sum at 0
    task automatic run_body(input bit b2b, input bit maxlat);
        int gap;
        int lat;
        for (int e = 0; e < int'(NE); e++) begin
            for (int s = 0; s < int'(NS); s++) begin
                gap = b2b ? 0 : int'($urandom_range(0, 7));
                lat = maxlat ? int'(TO) - 1 : (b2b ? 0 : int'($urandom_range(0, TO - 1)));
                do_sample(e, s, gap, lat, !b2b && ($urandom_range(0, 1) == 1));
                if (s < int'(NS) - 1) step();
                else do_epoch_end(e);
            end
        end
    endtask

    task automatic start_cmd();
        cmd_start = 1'b1;
        step();
        cmd_start = 1'b0;
        exp_loss = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        vectors++;
        if ({sample_ready, core_start, weight_commit, busy, epoch_done, train_done, error,
             sample_idx, epoch_idx, epoch_loss} !== 43'b0) begin
            miscompares++;
            $display("FAIL reset: outputs=%h want 0", {sample_ready, core_start, weight_commit, busy,
                     epoch_done, train_done, error, sample_idx, epoch_idx, epoch_loss});
        end
    endtask

    task automatic test_random_runs();
        for (int r = 0; r < 3; r++) begin
            start_cmd();
            run_body(1'b0, 1'b0);
        end
    endtask

    task automatic test_back_to_back();
        int c0, e0, t0;
        c0 = n_commit; e0 = n_edone; t0 = n_tdone;
        start_cmd();
        run_body(1'b1, 1'b0);
        step();
        vectors++;
        if ({n_commit - c0, n_edone - e0, n_tdone - t0} !== {32'(NS * NE), 32'(NE), 32'd1}) begin
            miscompares++;
            $display("FAIL pulse_counts: commits=%0d edone=%0d tdone=%0d want %0d %0d 1",
                     n_commit - c0, n_edone - e0, n_tdone - t0, NS * NE, NE);
        end
    endtask

    task automatic test_done_boundary();
        start_cmd();
        run_body(1'b0, 1'b1);
    endtask

    task automatic test_timeout();
        int c0;
        start_cmd();
        do_sample(0, 0, 0, 2, 1'b0);
        step();
        c0 = n_commit;
        sample_valid = 1'b1;
        step();
        sample_valid = 1'b0;
        step();
        for (int i = 0; i < int'(TO); i++) begin
            vectors++;
            if ({busy, error, weight_commit} !== 3'b100) begin
                miscompares++;
                $display("FAIL timeout_wait cyc%0d: busy/err/commit=%b want 100", i, {busy, error, weight_commit});
            end
            step();
        end
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if ({error, busy, weight_commit, sample_ready} !== 4'b1000) begin
                miscompares++;
                $display("FAIL error_sticky cyc%0d: err/busy/commit/ready=%b want 1000", i,
                         {error, busy, weight_commit, sample_ready});
            end
            step();
        end
        vectors++;
        if (n_commit != c0) begin
            miscompares++;
            $display("FAIL timeout_commit: commits=%0d want %0d", n_commit, c0);
        end
        start_cmd();
        vectors++;
        if ({sample_ready, error, sample_idx, epoch_idx} !== 6'b100000) begin
            miscompares++;
            $display("FAIL error_restart: ready/err/sidx/eidx=%b want 100000",
                     {sample_ready, error, sample_idx, epoch_idx});
        end
        run_body(1'b0, 1'b0);
    endtask

    task automatic test_abort();
        logic [31:0] kept;
        int c0;
        start_cmd();
        for (int s = 0; s < int'(NS); s++) begin
            do_sample(0, s, 1, 0, 1'b0);
            if (s < int'(NS) - 1) step();
            else do_epoch_end(0);
        end
        kept = last_loss;
        do_sample(1, 0, 0, 1, 1'b0);
        step();
        sample_valid = 1'b1;
        step();
        sample_valid = 1'b0;
        step();
        step();
        c0 = n_commit;
        core_done = 1'b1;
        cmd_abort = 1'b1;
        core_output = 16'($urandom);
        step();
        core_done = 1'b0;
        cmd_abort = 1'b0;
        vectors++;
        if ({busy, weight_commit, sample_ready, error, sample_idx, epoch_idx} !== 8'b0) begin
            miscompares++;
            $display("FAIL abort: busy/commit/ready/err/sidx/eidx=%b want 0",
                     {busy, weight_commit, sample_ready, error, sample_idx, epoch_idx});
        end
        vectors++;
        if (epoch_loss !== kept) begin
            miscompares++;
            $display("FAIL abort_loss: got %h want %h", epoch_loss, kept);
        end
        step();
        step();
        vectors++;
        if ({busy, n_commit - c0} !== {1'b0, 32'd0}) begin
            miscompares++;
            $display("FAIL abort_no_commit: busy=%b commits=%0d want 0 0", busy, n_commit - c0);
        end
        start_cmd();
        run_body(1'b0, 1'b0);
    endtask

    task automatic test_reset_midrun();
        start_cmd();
        sample_valid = 1'b1;
        step();
        sample_valid = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        last_loss = '0;
        vectors++;
        if ({sample_ready, core_start, weight_commit, busy, epoch_done, train_done, error,
             sample_idx, epoch_idx, epoch_loss} !== 43'b0) begin
            miscompares++;
            $display("FAIL reset_midrun: outputs=%h want 0", {sample_ready, core_start, weight_commit,
                     busy, epoch_done, train_done, error, sample_idx, epoch_idx, epoch_loss});
        end
    endtask

    task automatic test_saturation();
        longint m;
        int     pick;
        a_clear = 1'b1;
        step();
        a_clear = 1'b0;
        m = 0;
        for (int i = 0; i < 35; i++) begin
            pick = (i >= 10 && i < 30) ? 0 : int'($urandom_range(0, 2));
            a_pred  = (pick == 0) ? 16'h7FFF : (pick == 1) ? 16'h8000 : 16'($urandom);
            a_label = (pick == 0) ? 16'h8000 : (pick == 1) ? 16'h7FFF : 16'($urandom);
            a_en = ($urandom_range(0, 5) != 0);
            if (a_en) m = m + abs_err(a_pred, a_label);
            if (m > AMAX) m = AMAX;
            step();
            vectors++;
            if (a_sum !== AW'(m)) begin
                miscompares++;
                $display("FAIL accum cyc%0d: sum=%h want %h", i, a_sum, AW'(m));
            end
        end
        a_en = 1'b0;
        a_clear = 1'b1;
        step();
        a_clear = 1'b0;
        vectors++;
        if (a_sum !== '0) begin
            miscompares++;
            $display("FAIL accum_clear: sum=%h want 0", a_sum);
        end
    endtask

    initial begin
        test_reset();
        test_random_runs();
        test_back_to_back();
        test_done_boundary();
        test_timeout();
        test_abort();
        test_reset_midrun();
        test_random_runs();
        test_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
